// File: rtl/memory_access_scheduler_pkg.sv
// Shared types and width helpers for the memory access scheduler and its picker.
package memory_access_scheduler_pkg;

   // Scheduler FSM: waiting for a request, or holding the memory port for one access.
   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_e;

   // Width of a requester index; never narrower than one bit.
   function automatic int idx_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   // Width of the access watchdog counter; a disabled watchdog still gets one bit.
   function automatic int cnt_width(input int timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage

// File: rtl/memory_access_scheduler_if.sv
// Requester-side and memory-side signal bundle of the memory access scheduler.
interface memory_access_scheduler_if
   import memory_access_scheduler_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 128
) ();

   localparam int IDX_W = idx_width(NUM_REQ);

   logic [NUM_REQ-1:0]            reqValid;
   logic [NUM_REQ-1:0]            reqIsWrite;
   logic [NUM_REQ*ADDR_WIDTH-1:0] reqAddr;
   logic [NUM_REQ*DATA_WIDTH-1:0] reqWriteValue;
   logic [NUM_REQ-1:0]            grant;
   logic [NUM_REQ-1:0]            error;
   logic [DATA_WIDTH-1:0]         readValue;
   logic                          busy;
   logic [IDX_W-1:0]              owner;
   logic                          memEnable;
   logic                          memIsWrite;
   logic [ADDR_WIDTH-1:0]         memAddr;
   logic [DATA_WIDTH-1:0]         memWriteValue;
   logic [DATA_WIDTH-1:0]         memReadValue;
   logic                          memDone;

   // Scheduler view.
   modport slave (
      input  reqValid, reqIsWrite, reqAddr, reqWriteValue, memReadValue, memDone,
      output grant, error, readValue, busy, owner,
             memEnable, memIsWrite, memAddr, memWriteValue
   );

   // Environment view: requesters plus the memory.
   modport master (
      output reqValid, reqIsWrite, reqAddr, reqWriteValue, memReadValue, memDone,
      input  grant, error, readValue, busy, owner,
             memEnable, memIsWrite, memAddr, memWriteValue
   );

endinterface

// File: rtl/memory_access_scheduler_picker.sv
// Combinational round-robin picker: first requester after the last owner, wrapping.
module round_robin_picker
   import memory_access_scheduler_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic               found,
   output logic [IDX_W-1:0]   winner
);

   // Walk the slots owner+1 .. owner+NUM_REQ (mod NUM_REQ) and keep the first hit.
   always_comb begin
      int   idx_v;
      logic hit_v;
      found  = 1'b0;
      winner = '0;
      idx_v  = 0;
      hit_v  = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx_v  = (int'(last) + i) % NUM_REQ;
         hit_v  = req[idx_v] & ~found;
         winner = hit_v ? IDX_W'(idx_v) : winner;
         found  = found | req[idx_v];
      end
   end

endmodule

// File: rtl/memory_access_scheduler.sv
// Round-robin scheduler sharing one enable/done memory port between NUM_REQ
// requesters, with the winning request latched for the whole access and an
// optional per-access timeout watchdog.
module memory_access_scheduler
   import memory_access_scheduler_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 128,
   parameter int TIMEOUT    = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   memory_access_scheduler_if.slave  bus
);

   localparam int               IDX_W     = idx_width(NUM_REQ);
   localparam int               CNT_W     = cnt_width(TIMEOUT);
   localparam logic             TMO_EN    = (TIMEOUT > 0) ? 1'b1 : 1'b0;
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [IDX_W-1:0] OWNER_RST = IDX_W'(NUM_REQ - 1);

   state_e                state_q,    state_d;
   logic [IDX_W-1:0]      owner_q,    owner_d;
   logic                  is_write_q, is_write_d;
   logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
   logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
   logic [CNT_W-1:0]      cnt_q,      cnt_d;

   logic                  pick_found;
   logic [IDX_W-1:0]      pick_winner;
   logic                  done_s;
   logic                  tmo_s;
   logic [NUM_REQ-1:0]    grant_s;
   logic [NUM_REQ-1:0]    error_s;

   round_robin_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req    (bus.reqValid),
      .last   (owner_q),
      .found  (pick_found),
      .winner (pick_winner)
   );

   // A completing memDone always beats the watchdog in the same cycle.
   assign done_s = (state_q == ST_ACCESS) & bus.memDone;
   assign tmo_s  = TMO_EN & (state_q == ST_ACCESS) & (cnt_q == TMO_LAST) & ~bus.memDone;

   // Next state, request capture and watchdog counting.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      is_write_d = is_write_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d    = ST_ACCESS;
               owner_d    = pick_winner;
               is_write_d = bus.reqIsWrite[pick_winner];
               addr_d     = bus.reqAddr[pick_winner*ADDR_WIDTH +: ADDR_WIDTH];
               wdata_d    = bus.reqWriteValue[pick_winner*DATA_WIDTH +: DATA_WIDTH];
               cnt_d      = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (done_s || tmo_s) begin
               // Clearing the latches here keeps the memory bus at zero while idle.
               state_d    = ST_IDLE;
               is_write_d = 1'b0;
               addr_d     = '0;
               wdata_d    = '0;
               cnt_d      = '0;
            end else begin
               state_d = ST_ACCESS;
               cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_W'(1));
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Route the completion or timeout pulse to the current owner only.
   always_comb begin
      grant_s = '0;
      error_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_s[i] = done_s & (owner_q == IDX_W'(i));
         error_s[i] = tmo_s  & (owner_q == IDX_W'(i));
      end
   end

   // State and latched-request registers; reset drops the memory port at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWNER_RST;
         is_write_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         is_write_q <= is_write_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.memEnable     = (state_q == ST_ACCESS);
   assign bus.busy          = (state_q == ST_ACCESS);
   assign bus.memIsWrite    = is_write_q;
   assign bus.memAddr       = addr_q;
   assign bus.memWriteValue = wdata_q;
   assign bus.owner         = owner_q;
   assign bus.readValue     = bus.memReadValue;
   assign bus.grant         = grant_s;
   assign bus.error         = error_s;

endmodule

// File: tb/tb_memory_access_scheduler.sv
// Self-checking bench for memory_access_scheduler: requester/memory models plus
// a scoreboard of expected completions in service order.
module tb_memory_access_scheduler;

   localparam int NR = 4;
   localparam int AW = 32;
   localparam int DW = 128;
   localparam int TO = 8;

   typedef struct {
      int             idx;
      bit             is_err;
      logic [AW-1:0]  addr;
      logic           wr;
      logic [DW-1:0]  wdata;
   } exp_t;

   logic clk;
   logic rst;

   int            tests_run;
   int            fail_cnt;
   exp_t          sb_q[$];
   int            issued_cnt[NR];
   int            served_cnt[NR];
   logic [AW-1:0] m_addr[NR];
   logic          m_wr[NR];
   logic [DW-1:0] m_wd[NR];
   int            mem_lat;
   int            acc_cyc;
   logic [31:0]   rd_salt;

   exp_t          mon_e;
   logic [NR-1:0] mon_vec;
   logic [DW-1:0] mon_rd;

   memory_access_scheduler_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   memory_access_scheduler #(
      .NUM_REQ    (NR),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TIMEOUT    (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Requester model: a requester keeps asking while it has unserved issues.
   always_comb begin
      bus.reqValid = '0;
      for (int i = 0; i < NR; i++) bus.reqValid[i] = (issued_cnt[i] != served_cnt[i]);
   end

   // Memory model: done in access cycle mem_lat (1-based); 0 means never.
   always @(posedge clk or negedge rst) begin
      if (!rst) acc_cyc <= 0;
      else      acc_cyc <= bus.memEnable ? acc_cyc + 1 : 0;
   end
   assign bus.memDone      = bus.memEnable && (mem_lat != 0) && (acc_cyc == mem_lat - 1);
   assign bus.memReadValue = {bus.memAddr ^ 32'hA5A5_5A5A, rd_salt, 64'h0123_4567_89AB_CDEF};

   // Scoreboard consumer: every grant/error pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rst && (bus.grant != '0 || bus.error != '0)) begin
         if (sb_q.size() == 0) begin
            tests_run++; fail_cnt++;
            $display("FAIL unexpected_pulse: grant=%b error=%b, required no pulse", bus.grant, bus.error);
         end else begin
            mon_e   = sb_q.pop_front();
            mon_vec = 4'b0001 << mon_e.idx;
            tests_run++;
            if (mon_e.is_err) begin
               if (bus.error !== mon_vec || bus.grant !== 4'b0000) begin
                  fail_cnt++;
                  $display("FAIL error_pulse: grant=%b error=%b, required grant=0000 error=%b", bus.grant, bus.error, mon_vec);
               end
            end else begin
               if (bus.grant !== mon_vec || bus.error !== 4'b0000) begin
                  fail_cnt++;
                  $display("FAIL grant_pulse: grant=%b error=%b, required grant=%b error=0000", bus.grant, bus.error, mon_vec);
               end
            end
            tests_run++;
            if (bus.owner !== 2'(mon_e.idx)) begin
               fail_cnt++;
               $display("FAIL pulse_owner: owner=%0d, required %0d", bus.owner, mon_e.idx);
            end
            tests_run++;
            if (bus.memAddr !== mon_e.addr || bus.memIsWrite !== mon_e.wr || bus.memWriteValue !== mon_e.wdata) begin
               fail_cnt++;
               $display("FAIL latched_bus: addr=%h wr=%b wdata=%h, required addr=%h wr=%b wdata=%h",
                        bus.memAddr, bus.memIsWrite, bus.memWriteValue, mon_e.addr, mon_e.wr, mon_e.wdata);
            end
            if (!mon_e.is_err) begin
               mon_rd = {mon_e.addr ^ 32'hA5A5_5A5A, rd_salt, 64'h0123_4567_89AB_CDEF};
               tests_run++;
               if (bus.readValue !== mon_rd) begin
                  fail_cnt++;
                  $display("FAIL read_value: got %h, required %h", bus.readValue, mon_rd);
               end
            end
         end
         for (int i = 0; i < NR; i++) if (bus.grant[i] || bus.error[i]) served_cnt[i]++;
      end
   end

   // Set one requester's inputs and remember them for the scoreboard.
   task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      bus.reqIsWrite[i]            = wr;
      bus.reqAddr[i*AW +: AW]      = a;
      bus.reqWriteValue[i*DW +: DW] = wd;
      m_wr[i]   = wr;
      m_addr[i] = a;
      m_wd[i]   = wd;
   endtask

   task automatic push_exp(input int i, input bit is_err);
      exp_t e;
      e.idx = i; e.is_err = is_err; e.addr = m_addr[i]; e.wr = m_wr[i]; e.wdata = m_wd[i];
      sb_q.push_back(e);
   endtask

   task automatic drain(input int max_cyc);
      for (int k = 0; k < max_cyc; k++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && bus.reqValid == 4'b0000 && !bus.memEnable) break;
      end
   endtask

   task automatic test_reset;
      logic [DW-1:0] rd_exp;
      @(negedge clk);
      rd_exp = {32'hA5A5_5A5A, rd_salt, 64'h0123_4567_89AB_CDEF};
      tests_run++; if (bus.memEnable !== 1'b0) begin fail_cnt++; $display("FAIL rst_memEnable: got %b, required 0", bus.memEnable); end
      tests_run++; if (bus.busy !== 1'b0) begin fail_cnt++; $display("FAIL rst_busy: got %b, required 0", bus.busy); end
      tests_run++; if (bus.owner !== 2'd3) begin fail_cnt++; $display("FAIL rst_owner: got %0d, required 3", bus.owner); end
      tests_run++; if (bus.grant !== 4'b0000 || bus.error !== 4'b0000) begin fail_cnt++; $display("FAIL rst_pulses: grant=%b error=%b, required 0", bus.grant, bus.error); end
      tests_run++; if (bus.memAddr !== 32'h0 || bus.memIsWrite !== 1'b0) begin fail_cnt++; $display("FAIL rst_addr: addr=%h wr=%b, required 0", bus.memAddr, bus.memIsWrite); end
      tests_run++; if (bus.memWriteValue !== 128'h0) begin fail_cnt++; $display("FAIL rst_wdata: got %h, required 0", bus.memWriteValue); end
      tests_run++; if (bus.readValue !== rd_exp) begin fail_cnt++; $display("FAIL idle_readValue: got %h, required %h", bus.readValue, rd_exp); end
      rst = 1'b1;
      @(negedge clk);
      tests_run++; if (bus.memEnable !== 1'b0) begin fail_cnt++; $display("FAIL idle_no_req: memEnable=%b, required 0", bus.memEnable); end
   endtask

   task automatic test_round_robin;
      logic exp_en;
      mem_lat = 1;
      rd_salt = 32'h3333_0001;
      for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'h0000_0100 * (i + 1), {4{32'hC0DE_0000 + i}});
      push_exp(0, 1'b0); push_exp(1, 1'b0); push_exp(2, 1'b0); push_exp(3, 1'b0); push_exp(0, 1'b0);
      issued_cnt[0] += 2; issued_cnt[1]++; issued_cnt[2]++; issued_cnt[3]++;
      for (int k = 0; k < 10 && !bus.memEnable; k++) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         exp_en = ((k % 2) == 0);
         tests_run++;
         if (bus.memEnable !== exp_en) begin
            fail_cnt++;
            $display("FAIL rr_spacing: cycle %0d memEnable=%b, required %b", k, bus.memEnable, exp_en);
         end
         @(negedge clk);
      end
      drain(20);
      tests_run++; if (sb_q.size() != 0) begin fail_cnt++; $display("FAIL rr_drain: %0d expected grants missing, required 0", sb_q.size()); end
      tests_run++; if (bus.owner !== 2'd0) begin fail_cnt++; $display("FAIL rr_last_owner: got %0d, required 0", bus.owner); end
   endtask

   task automatic test_single_read;
      int en_cnt;
      int addr_bad;
      mem_lat = 3;
      rd_salt = 32'h2222_0002;
      set_req(2, 1'b0, 32'h0000_1000, {4{32'h5151_5151}});
      push_exp(2, 1'b0);
      issued_cnt[2]++;
      @(negedge clk);
      tests_run++; if (bus.memEnable !== 1'b1) begin fail_cnt++; $display("FAIL read_latency: memEnable=%b one cycle after request, required 1", bus.memEnable); end
      en_cnt = 0; addr_bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (bus.memEnable) begin
            en_cnt++;
            if (bus.memAddr !== 32'h0000_1000 || bus.busy !== 1'b1) addr_bad++;
         end else if (en_cnt > 0) break;
         @(negedge clk);
      end
      tests_run++; if (en_cnt != 3) begin fail_cnt++; $display("FAIL read_enable_len: got %0d cycles, required 3", en_cnt); end
      tests_run++; if (addr_bad != 0) begin fail_cnt++; $display("FAIL read_addr_busy: %0d bad cycles, required 0", addr_bad); end
      tests_run++; if (bus.owner !== 2'd2 || bus.busy !== 1'b0) begin fail_cnt++; $display("FAIL read_after: owner=%0d busy=%b, required owner=2 busy=0", bus.owner, bus.busy); end
      drain(10);
      tests_run++; if (sb_q.size() != 0) begin fail_cnt++; $display("FAIL read_drain: %0d missing, required 0", sb_q.size()); end
   endtask

   task automatic test_write;
      logic [DW-1:0] wd;
      int en_cnt;
      int bad;
      wd = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1234_5678;
      mem_lat = 4;
      set_req(1, 1'b1, 32'h2000_0040, wd);
      push_exp(1, 1'b0);
      issued_cnt[1]++;
      for (int k = 0; k < 10 && !bus.memEnable; k++) @(negedge clk);
      en_cnt = 0; bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (bus.memEnable) begin
            en_cnt++;
            if (bus.memIsWrite !== 1'b1 || bus.memWriteValue !== wd || bus.memAddr !== 32'h2000_0040) bad++;
            if (en_cnt == 2) begin
               bus.reqWriteValue[1*DW +: DW] = ~wd;
               bus.reqAddr[1*AW +: AW]       = 32'hFFFF_0000;
               bus.reqIsWrite[1]             = 1'b0;
            end
         end else if (en_cnt > 0) break;
         @(negedge clk);
      end
      tests_run++; if (en_cnt != 4) begin fail_cnt++; $display("FAIL write_enable_len: got %0d, required 4", en_cnt); end
      tests_run++; if (bad != 0) begin fail_cnt++; $display("FAIL write_stable: %0d unstable cycles, required 0", bad); end
      drain(10);
      tests_run++; if (sb_q.size() != 0) begin fail_cnt++; $display("FAIL write_drain: %0d missing, required 0", sb_q.size()); end
      set_req(1, 1'b0, 32'h0, 128'h0);
   endtask

   task automatic test_timeout;
      int en_cnt;
      int err_at;
      mem_lat = 0;
      rd_salt = 32'h4444_0004;
      set_req(2, 1'b0, 32'h0000_3000, {4{32'h6666_0002}});
      set_req(3, 1'b1, 32'h0000_4000, {4{32'h7777_0003}});
      push_exp(2, 1'b1); push_exp(3, 1'b0);
      issued_cnt[2]++; issued_cnt[3]++;
      for (int k = 0; k < 10 && !bus.memEnable; k++) @(negedge clk);
      en_cnt = 0; err_at = 0;
      for (int k = 0; k < 30; k++) begin
         if (bus.memEnable) en_cnt++;
         if (bus.error != 4'b0000) begin err_at = en_cnt; break; end
         @(negedge clk);
      end
      tests_run++; if (err_at != TO) begin fail_cnt++; $display("FAIL timeout_cycle: error in access cycle %0d, required %0d", err_at, TO); end
      mem_lat = 2;
      @(negedge clk);
      tests_run++; if (bus.memEnable !== 1'b0) begin fail_cnt++; $display("FAIL timeout_idle: memEnable=%b, required 0", bus.memEnable); end
      @(negedge clk);
      tests_run++; if (bus.memEnable !== 1'b1 || bus.owner !== 2'd3) begin fail_cnt++; $display("FAIL timeout_next: memEnable=%b owner=%0d, required 1 and 3", bus.memEnable, bus.owner); end
      drain(10);
      tests_run++; if (sb_q.size() != 0) begin fail_cnt++; $display("FAIL timeout_drain: %0d missing, required 0", sb_q.size()); end
   endtask

   task automatic test_tie;
      int en_cnt;
      int err_seen;
      mem_lat = TO;
      set_req(0, 1'b0, 32'h0000_5000, {4{32'h8888_0000}});
      push_exp(0, 1'b0);
      issued_cnt[0]++;
      for (int k = 0; k < 10 && !bus.memEnable; k++) @(negedge clk);
      en_cnt = 0; err_seen = 0;
      for (int k = 0; k < 30; k++) begin
         if (bus.memEnable) en_cnt++;
         else if (en_cnt > 0) break;
         if (bus.error != 4'b0000) err_seen++;
         @(negedge clk);
      end
      tests_run++; if (en_cnt != TO) begin fail_cnt++; $display("FAIL tie_enable_len: got %0d, required %0d", en_cnt, TO); end
      tests_run++; if (err_seen != 0) begin fail_cnt++; $display("FAIL tie_error: %0d error cycles, required 0", err_seen); end
      drain(10);
      tests_run++; if (sb_q.size() != 0) begin fail_cnt++; $display("FAIL tie_drain: %0d missing, required 0", sb_q.size()); end
   endtask

   task automatic test_reset_mid_access;
      mem_lat = 0;
      set_req(3, 1'b0, 32'h0000_6000, {4{32'h9999_0003}});
      issued_cnt[3]++;
      for (int k = 0; k < 10 && !bus.memEnable; k++) @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      tests_run++; if (bus.memEnable !== 1'b0 || bus.busy !== 1'b0) begin fail_cnt++; $display("FAIL async_reset: memEnable=%b busy=%b, required 0", bus.memEnable, bus.busy); end
      tests_run++; if (bus.grant !== 4'b0000 || bus.memAddr !== 32'h0) begin fail_cnt++; $display("FAIL async_reset_bus: grant=%b addr=%h, required 0", bus.grant, bus.memAddr); end
      set_req(0, 1'b0, 32'h0000_7000, {4{32'hAAAA_0000}});
      issued_cnt[0]++;
      mem_lat = 2;
      push_exp(0, 1'b0); push_exp(3, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      drain(20);
      tests_run++; if (sb_q.size() != 0) begin fail_cnt++; $display("FAIL reset_reissue: %0d missing, required 0", sb_q.size()); end
   endtask

   initial begin
      tests_run = 0; fail_cnt = 0;
      rst = 1'b0; mem_lat = 0; rd_salt = 32'h1111_0000;
      for (int i = 0; i < NR; i++) begin issued_cnt[i] = 0; served_cnt[i] = 0; end
      bus.reqIsWrite = '0; bus.reqAddr = '0; bus.reqWriteValue = '0;
      for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'h0, 128'h0);
      test_reset();
      test_round_robin();
      test_single_read();
      test_write();
      test_timeout();
      test_tie();
      test_reset_mid_access();
      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
